// File: rtl/osc_readout_pkg.sv
// Shared definitions for the oscillator readout path.
// Holds the oscillator count, the select width and the record layout helpers.
// Record layout, MSB to LSB: {osc, round, sat, count}.
package osc_readout_pkg;

    localparam int unsigned NUM_OSC = 10;
    localparam int unsigned OSC_W   = 5;
    localparam int unsigned SAT_W   = 1;

    // Default field layout (CntW = 24, RoundW = 8)
    localparam int unsigned CNT_W     = 24;
    localparam int unsigned ROUND_W   = 8;
    localparam int unsigned SAT_BIT   = CNT_W;
    localparam int unsigned ROUND_LSB = CNT_W + SAT_W;
    localparam int unsigned OSC_LSB   = CNT_W + SAT_W + ROUND_W;

    function automatic int unsigned rec_width(int unsigned cnt_w, int unsigned round_w);
        return OSC_W + round_w + SAT_W + cnt_w;
    endfunction

    function automatic int unsigned sat_bit(int unsigned cnt_w);
        return cnt_w;
    endfunction

    function automatic int unsigned round_lsb(int unsigned cnt_w);
        return cnt_w + SAT_W;
    endfunction

    function automatic int unsigned osc_lsb(int unsigned cnt_w, int unsigned round_w);
        return cnt_w + SAT_W + round_w;
    endfunction

endpackage

// File: rtl/osc_sample_capture_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (flushes pointers)
//   push_i, data_i   write request and data
//   pop_i            read request (ignored when empty)
//   data_o           head entry, forced to zero while empty
//   full_o, empty_o  status flags
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (rd_en) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/osc_sample_capture.sv
// osc_sample_capture: counts rising edges of the selected ring oscillator and,
// on each sample strobe, queues a {osc, round, sat, count} record for the
// SRAM writer.
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   osc_i            raw oscillator outputs (asynchronous)
//   OscSel_i         oscillator select
//   Sample_i         one-cycle capture strobe
//   Resetn_i         measurement reset (0 clears count and sat)
//   rec_valid_o/rec_ready_i/rec_data_o   record output handshake
//   overflow_o       sticky, a record was dropped on a full FIFO
//   drop_cnt_o       saturating count of dropped records
module osc_sample_capture
    import osc_readout_pkg::*;
#(
    parameter int unsigned NumOsc    = NUM_OSC,
    parameter int unsigned CntW      = 24,
    parameter int unsigned RoundW    = 8,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NumOsc-1:0]                  osc_i,
    input  logic [OSC_W-1:0]                   OscSel_i,
    input  logic                               Sample_i,
    input  logic                               Resetn_i,
    output logic                               rec_valid_o,
    input  logic                               rec_ready_i,
    output logic [rec_width(CntW, RoundW)-1:0] rec_data_o,
    output logic                               overflow_o,
    output logic [7:0]                         drop_cnt_o
);

    localparam int unsigned        RecW    = rec_width(CntW, RoundW);
    localparam logic [OSC_W-1:0]   LastSel = OSC_W'(NumOsc - 1);

    logic [NumOsc-1:0] sync1_q, sync2_q;
    logic [OSC_W-1:0]  sel_q;
    logic              prev_q, prev_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              sat_q, sat_d;
    logic [RoundW-1:0] round_q, round_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [31:0]       sync_pad;
    logic              sel_valid, new_valid, sel_change;
    logic              cur_bit, new_bit, edge_det;
    logic              push_req, pop, drop, fifo_full, fifo_empty;
    logic [RecW-1:0]   push_data;

    // Padding to 32 bits lets the 5-bit select index any value safely
    assign sync_pad   = 32'(sync2_q);
    assign sel_valid  = (sel_q <= LastSel);
    assign new_valid  = (OscSel_i <= LastSel);
    assign sel_change = (OscSel_i != sel_q);
    assign cur_bit    = sel_valid && sync_pad[sel_q];
    assign new_bit    = new_valid && sync_pad[OscSel_i];

    // On a select switch the detector is preloaded with the new oscillator's
    // level so the switch itself never looks like an edge
    assign edge_det = cur_bit && !prev_q && !sel_change;
    assign prev_d   = sel_change ? new_bit : cur_bit;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (!Resetn_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (edge_det) begin
            if (count_q == '1) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + {{(CntW-1){1'b0}}, 1'b1};
                if (count_d == '1) sat_d = 1'b1;
            end
        end
    end

    // Record carries the post-update count so a same-cycle edge is included
    assign push_req  = Sample_i && sel_valid;
    assign pop       = rec_valid_o && rec_ready_i;
    assign drop      = push_req && fifo_full && !pop;
    assign push_data = {sel_q, round_q, sat_d, count_d};

    always_comb begin
        round_d    = round_q;
        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (push_req && (sel_q == LastSel)) round_d = round_q + {{(RoundW-1){1'b0}}, 1'b1};
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sel_q      <= '0;
            prev_q     <= 1'b0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            round_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sync1_q    <= osc_i;
            sync2_q    <= sync1_q;
            sel_q      <= OscSel_i;
            prev_q     <= prev_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            round_q    <= round_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .Width (RecW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_req),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (rec_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rec_valid_o = !fifo_empty;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/osc_sample_capture.md
# osc_sample_capture

Receive-side partner of the readout counter controller: consumes the oscillator select, sample strobe and measurement reset it issues, and counts rising edges of the selected aging ring oscillator. On each sample strobe it packs the count into a record and buffers it in a small FIFO. A valid/ready port drains the FIFO to the SRAM writer. It sits between the oscillator bank and the readout SRAM in the readoutnet.

## Interface
- NumOsc, 10, number of oscillators; legal select values 0..NumOsc-1.
- CntW, 24, edge counter width.
- RoundW, 8, sweep (round) index width.
- FifoDepth, 4, record FIFO depth; power of two, at least 2.

- clk  input  1  system clock.
- rstn  input  1  asynchronous, active-low reset.
- osc_i  input  NumOsc  raw oscillator outputs, asynchronous to clk.
- OscSel_i  input  5  oscillator select from the controller.
- Sample_i  input  1  one-cycle capture strobe.
- Resetn_i  input  1  measurement reset: 0 clears the count, 1 enables counting.
- rec_valid_o  output  1  a record is available.
- rec_ready_i  input  1  the downstream block accepts the record.
- rec_data_o  output  14+CntW  record: [CntW+13:CntW+9] osc, [CntW+8:CntW+1] round, [CntW] sat, [CntW-1:0] count.
- overflow_o  output  1  sticky: a record was dropped because the FIFO was full.
- drop_cnt_o  output  8  number of dropped records; saturates at 255.

## Operation
- Each osc_i bit passes through its own 2-flop synchronizer.
- The selected synchronized bit feeds a rising-edge detector (previous-value register).
- OscSel_i is registered as sel_q. When OscSel_i differs from sel_q, the edge detector reloads and no edge is counted that cycle. This prevents false edges on a select switch.
- Count:
  - Cleared to 0, and sat cleared, in any cycle where Resetn_i=0.
  - Otherwise incremented on each detected edge.
  - Saturates at 2^CntW-1 and sets sat, which holds until the next clear.
- When sel_q >= NumOsc, edges are ignored.
- Capture on Sample_i=1 with sel_q < NumOsc:
  - Push {sel_q, round, sat, count_next}, where count_next includes any edge detected in the same cycle.
  - If Resetn_i=0 in the same cycle, the record carries count 0.
  - Sample_i with sel_q >= NumOsc is ignored: no push, no drop.
- FIFO full on push:
  - The record is dropped.
  - overflow_o is set and drop_cnt_o increments (saturating).
  - A simultaneous pop and push when full is accepted; it is not a drop.
- Round counter:
  - Increments in the cycle after a push or drop whose sel_q = NumOsc-1.
  - Wraps modulo 2^RoundW.
- Output handshake:
  - rec_data_o equals the FIFO head.
  - A pop occurs when rec_valid_o && rec_ready_i.
  - While rec_valid_o && !rec_ready_i, rec_data_o is held stable.
- Reset values: rec_valid_o=0, rec_data_o=0, overflow_o=0, drop_cnt_o=0. Internal count, round, sat, sel_q, synchronizers and FIFO pointers are also 0.
- rstn asserted mid-operation flushes the FIFO; in-flight records are lost.

## Timing
- Oscillator rising edge to count increment: 3 clk cycles (2 sync + 1 detect).
- osc_i high and low phases must each be at least 2 clk periods. Faster oscillators are out of spec and undercount silently.
- Sample_i to rec_valid_o high (FIFO empty): 1 cycle.
- Back-to-back pops sustain 1 record per cycle.
- OscSel_i to counting the new oscillator: the first edge is counted at the earliest 3 cycles after the select change.
- The controller holds Resetn_i low for at least one cycle between samples; the block does not require it.

## Structure
- Shared package osc_readout_pkg holds:
  - NUM_OSC.
  - The record field widths and offsets (OSC_LSB, ROUND_LSB, SAT_BIT).
  - The record width function of CntW and RoundW.
- Sub-module sync_fifo: parameterised width and depth, with full/empty flags and simultaneous push/pop. The capture logic, synchronizers and counters stay in the top level.

## Test plan
- Select 3, Resetn_i=1, 100 edges on osc_i[3] at period 8 clk, then Sample_i -> one record with osc=3, count=100, sat=0, round=0.
- CntW=4 build, 20 edges, then Sample_i -> count=15, sat=1. Then Resetn_i=0 for 1 cycle and Sample_i -> count=0, sat=0.
- Full sweep of selects 0..9 with rec_ready_i=1 -> records 0..9 carry round=0, and the next sweep carries round=1. Toggling unselected oscillators does not change any count.
- rec_ready_i=0 and 6 samples with FifoDepth=4 -> 4 records held, overflow_o=1, drop_cnt_o=2. rec_data_o stays stable until ready, then the 4 records drain in order.
- Edge detected in the same cycle as Sample_i -> the record includes that edge. OscSel_i=12 with Sample_i -> no record and no drop.
- rstn pulsed low with 3 records queued -> rec_valid_o=0 on the next cycle, all counters 0, overflow_o=0.
